hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
//
// PURPOSE
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// Sits beside the combinational ALU in the execute stage and accepts the ALU's MUL (4'b0101) and DIV (4'b0110) opcodes.
// Computes each operation over multiple cycles and writes the result into HI/LO.
// Serves mfhi/mflo reads back to the datapath; the CPU stalls on busy.
//
// PARAMETERS
// N  32  operand/register width (even, >=4)
// M  4   opcode width, matches ALU alu_decode
//
// PORTS
// clk         in   1    rising-edge clock
// rst_n       in   1    asynchronous active-low reset
// start       in   1    request pulse; sampled only when busy=0
// alu_decode  in   M    opcode qualified by start; only MUL/DIV accepted
// rda         in   N    operand A (multiplicand / dividend), unsigned
// rdx         in   N    operand B (multiplier / divisor), unsigned
// rd_sel      in   2    read select: 2'b01 mfhi, 2'b10 mflo, else 0
// rd_data     out  N    combinational read of HI/LO per rd_sel
// busy        out  1    operation in flight
// done        out  1    one-cycle pulse on the cycle HI/LO update
// div_zero    out  1    sticky until next accepted start; set on DIV by 0
// hi          out  N    HI register (MUL upper half / DIV remainder)
// lo          out  N    LO register (MUL lower half / DIV quotient)
//
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; hi, lo, busy, done, div_zero = 0; count=0.
// - States: IDLE, MUL, DIV, FIN.
// - Transitions:
//   - IDLE -> MUL on start & alu_decode==MUL.
//   - IDLE -> DIV on start & alu_decode==DIV & rdx!=0.
//   - IDLE -> FIN on start & DIV & rdx==0.
//   - MUL/DIV -> FIN when count==N-1.
//   - FIN -> IDLE always.
// - Accept: operands latched on the accepting edge; busy=1 from the next cycle until FIN exits.
// - start while busy=1: ignored. start with any other opcode: ignored, no state change.
// - MUL: shift-add, one multiplier bit per cycle; 2N-bit accumulator; unsigned.
// - DIV: restoring division, one quotient bit per cycle; N+1-bit partial remainder.
// - Latency: accept at edge 0; FIN entered after edge N.
//   - In FIN: hi/lo written and done=1 for exactly one cycle; busy drops the following cycle.
//   - Back-to-back start is accepted the cycle after FIN.
// - DIV by zero: 1 cycle to FIN; lo = all ones, hi = rda, div_zero = 1.
// - hi/lo hold prior values throughout MUL/DIV; only the FIN cycle updates them.
// - rd_data: purely combinational; returns committed hi/lo even while busy.
// - Reset mid-operation: aborts immediately; no partial result is ever written.
// - count: $clog2(N) bits; wraps only under FSM control, never free-runs.
//
// STRUCTURE
// - Package mdu_pkg:
//   - localparams ALU_MUL=4'b0101, ALU_DIV=4'b0110 (shared with ALU decode).
//   - typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} mdu_state_t.
//   - localparams RD_HI=2'b01, RD_LO=2'b10.
// - Sub-module div_step (combinational):
//   - inputs: partial remainder, divisor, next dividend bit.
//   - outputs: new remainder, quotient bit.
// - The multiply step stays inline.
//
// TESTING
// - MUL 7*6: done at cycle N+1 after accept; hi=0, lo=42; rd_sel=2'b10 gives rd_data=42.
// - MUL 32'hFFFF_FFFF * 32'hFFFF_FFFF: hi=32'hFFFF_FFFE, lo=32'h0000_0001.
// - DIV 100/7: lo=14, hi=2, div_zero=0; DIV 5/0: done after 1 cycle, lo=32'hFFFF_FFFF, hi=5, div_zero=1.
// - start during busy, and start with opcode 4'b0001: both ignored; hi/lo and cycle count unchanged.
// - rst_n low mid-DIV (count=10): busy=0, hi=lo=0 asynchronously; no done pulse; next MUL 3*3 gives lo=9.
// - Back-to-back MUL 2*3 then DIV 9/2: second start accepted the cycle after done; lo=6, then lo=4, hi=1.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared opcodes, FSM state type and read-select encodings for the HI/LO mul/div unit.
package mdu_pkg;

  localparam logic [3:0] ALU_MUL = 4'b0101;
  localparam logic [3:0] ALU_DIV = 4'b0110;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} mdu_state_t;

  localparam logic [1:0] RD_HI = 2'b01;
  localparam logic [1:0] RD_LO = 2'b10;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit and subtract the divisor if it fits.
module div_step #(
  parameter int unsigned N = 32
) (
  input  logic [N:0]   rem,
  input  logic [N-1:0] divisor,
  input  logic         bit_in,
  output logic [N:0]   rem_out,
  output logic         q_bit
);

  logic [N+1:0] shifted;
  logic [N:0]   diff;

  always_comb begin
    shifted = {rem, bit_in};
    diff    = shifted[N:0] - {1'b0, divisor};
    q_bit   = (shifted >= {2'b00, divisor});
    rem_out = q_bit ? diff : shifted[N:0];
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative unsigned multiply/divide unit owning the architectural HI/LO registers.
module hilo_muldiv_unit
  import mdu_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] alu_decode,
  input  logic [N-1:0] rda,
  input  logic [N-1:0] rdx,
  input  logic [1:0]   rd_sel,
  output logic [N-1:0] rd_data,
  output logic         busy,
  output logic         done,
  output logic         div_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  mdu_state_t state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   opb_q, opb_d;
  logic [N:0]     rem_q, rem_d;
  logic [N-1:0]   hi_d, lo_d;
  logic           busy_d, done_d, div_zero_d;

  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_acc;
  logic [N:0]     step_rem;
  logic           step_q;

  div_step #(.N(N)) u_div_step (
    .rem     (rem_q),
    .divisor (opb_q),
    .bit_in  (acc_q[N-1]),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Shift-add: upper half accumulates the multiplicand, lower half drains the multiplier.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opb_q} : (N+1)'(0));
    mul_acc = {mul_sum, acc_q[N-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      rem_q    <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      rem_q    <= rem_d;
      hi       <= hi_d;
      lo       <= lo_d;
      busy     <= busy_d;
      done     <= done_d;
      div_zero <= div_zero_d;
    end
  end

  // Next state and next register values; HI/LO are only written on the edge entering FIN.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    rem_d      = rem_q;
    hi_d       = hi;
    lo_d       = lo;
    done_d     = 1'b0;
    div_zero_d = div_zero;

    unique case (state_q)
      IDLE: begin
        if (start && alu_decode == M'(ALU_MUL)) begin
          state_d    = MUL;
          count_d    = '0;
          acc_d      = {N'(0), rdx};
          opb_d      = rda;
          div_zero_d = 1'b0;
        end else if (start && alu_decode == M'(ALU_DIV)) begin
          if (rdx == '0) begin
            state_d    = FIN;
            hi_d       = rda;
            lo_d       = '1;
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            state_d    = DIV;
            count_d    = '0;
            acc_d      = {N'(0), rda};
            opb_d      = rdx;
            rem_d      = '0;
            div_zero_d = 1'b0;
          end
        end
      end
      MUL: begin
        acc_d   = mul_acc;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d = FIN;
          count_d = '0;
          hi_d    = mul_acc[2*N-1:N];
          lo_d    = mul_acc[N-1:0];
          done_d  = 1'b1;
        end
      end
      DIV: begin
        acc_d   = {acc_q[2*N-1:N], acc_q[N-2:0], step_q};
        rem_d   = step_rem;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d = FIN;
          count_d = '0;
          hi_d    = step_rem[N-1:0];
          lo_d    = {acc_q[N-2:0], step_q};
          done_d  = 1'b1;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_comb begin
    unique case (rd_sel)
      RD_HI:   rd_data = hi;
      RD_LO:   rd_data = lo;
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: fixed vectors, corner sequences and random ops vs. an arithmetic model.
module tb_hilo_muldiv_unit;
  import mdu_pkg::*;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [3:0]    alu_decode;
  logic [N-1:0]  rda, rdx;
  logic [1:0]    rd_sel;
  logic [N-1:0]  rd_data, hi, lo;
  logic          busy, done, div_zero;

  int n_vec = 0;
  int n_err = 0;
  logic [N-1:0] prev_hi, prev_lo;
  logic         prev_dz;

  hilo_muldiv_unit #(.N(N), .M(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .alu_decode (alu_decode),
    .rda        (rda),
    .rdx        (rdx),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [31:0] a, b;
    logic [31:0] ehi, elo;
    logic        edz;
    int          elat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the architectural result.
  task automatic model(input logic [3:0] op, input logic [31:0] a, b,
                       output logic [31:0] ehi, elo, output logic edz, output int elat);
    logic [63:0] prod;
    if (op == ALU_MUL) begin
      prod = 64'(a) * 64'(b);
      ehi = prod[63:32]; elo = prod[31:0]; edz = 1'b0; elat = N;
    end else if (b == 0) begin
      ehi = a; elo = '1; edz = 1'b1; elat = 0;
    end else begin
      ehi = a % b; elo = a / b; edz = 1'b0; elat = N;
    end
  endtask

  // Issue one op at a negedge in IDLE; returns at the negedge of the first idle cycle after FIN.
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a, b,
                       input logic [31:0] ehi, elo, input logic edz, input int elat, input bit inject);
    int lat;
    bit seen;
    alu_decode = op; rda = a; rdx = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; alu_decode = 4'($urandom); rda = $urandom; rdx = $urandom;
    lat = 0; seen = 0;
    while (lat <= N + 4) begin
      if (done) begin seen = 1; break; end
      if (lat == 3) begin
        chk({name, " hold_hi"}, 64'(hi), 64'(prev_hi));
        chk({name, " hold_lo"}, 64'(lo), 64'(prev_lo));
      end
      if (inject && lat == 5) begin
        start = 1'b1; alu_decode = ALU_DIV; rda = 32'd1000; rdx = 32'd3;
      end
      if (inject && lat == 6) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({name, " done_cycle"}, seen ? 64'(lat + 1) : 64'hdead, 64'(elat + 1));
    if (seen) begin
      chk({name, " hi"}, 64'(hi), 64'(ehi));
      chk({name, " lo"}, 64'(lo), 64'(elo));
      chk({name, " div_zero"}, 64'(div_zero), 64'(edz));
      chk({name, " busy_in_fin"}, 64'(busy), 64'(1));
      rd_sel = RD_LO; #1;
      chk({name, " rd_lo"}, 64'(rd_data), 64'(elo));
      rd_sel = RD_HI; #1;
      chk({name, " rd_hi"}, 64'(rd_data), 64'(ehi));
      rd_sel = 2'b00;
      @(negedge clk);
      chk({name, " busy_after"}, 64'(busy), 64'(0));
      chk({name, " done_pulse"}, 64'(done), 64'(0));
    end
    prev_hi = ehi; prev_lo = elo; prev_dz = edz;
  endtask

  vec_t tbl[7];

  initial begin
    logic [31:0] ehi, elo, a, b;
    logic [3:0]  op;
    logic        edz;
    int          elat;
    bit          any_done;

    tbl[0] = '{"mul_7x6",      ALU_MUL, 32'd7,        32'd6,        32'd0,        32'd42,       1'b0, N};
    tbl[1] = '{"mul_max",      ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, N};
    tbl[2] = '{"div_100_7",    ALU_DIV, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, N};
    tbl[3] = '{"mul_by_zero",  ALU_MUL, 32'h1234_5678, 32'd0,        32'd0,        32'd0,        1'b0, N};
    tbl[4] = '{"div_max_1",    ALU_DIV, 32'hFFFF_FFFF, 32'd1,        32'd0,        32'hFFFF_FFFF, 1'b0, N};
    tbl[5] = '{"div_1_max",    ALU_DIV, 32'd1,        32'hFFFF_FFFF, 32'd1,        32'd0,        1'b0, N};
    tbl[6] = '{"div_5_0",      ALU_DIV, 32'd5,        32'd0,        32'd5,        32'hFFFF_FFFF, 1'b1, 0};

    rst_n = 1'b0; start = 1'b0; alu_decode = '0; rda = '0; rdx = '0; rd_sel = 2'b00;
    prev_hi = '0; prev_lo = '0; prev_dz = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset hi", 64'(hi), 64'(0));
    chk("reset lo", 64'(lo), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset div_zero", 64'(div_zero), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      do_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ehi, tbl[i].elo,
            tbl[i].edz, tbl[i].elat, 1'b0);

    // Unsupported opcode in IDLE: nothing moves, sticky div_zero survives.
    start = 1'b1; alu_decode = 4'b0001; rda = 32'd9; rdx = 32'd9;
    @(negedge clk);
    start = 1'b0;
    chk("badop busy", 64'(busy), 64'(0));
    chk("badop done", 64'(done), 64'(0));
    @(negedge clk);
    chk("badop hi", 64'(hi), 64'(prev_hi));
    chk("badop lo", 64'(lo), 64'(prev_lo));
    chk("badop div_zero_sticky", 64'(div_zero), 64'(1));
    rd_sel = 2'b11; #1;
    chk("rd_sel_11", 64'(rd_data), 64'(0));
    rd_sel = 2'b00;

    // start while busy must be ignored.
    do_op("mul_inject", ALU_MUL, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, N, 1'b1);

    // Reset in the middle of a division (count == 10).
    alu_decode = ALU_DIV; rda = 32'd1000; rdx = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0; #1;
    chk("midrst busy", 64'(busy), 64'(0));
    chk("midrst hi", 64'(hi), 64'(0));
    chk("midrst lo", 64'(lo), 64'(0));
    chk("midrst done", 64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    any_done = 0;
    repeat (N + 4) begin
      @(negedge clk);
      if (done || busy) any_done = 1;
    end
    chk("midrst no_resume", 64'(any_done), 64'(0));
    prev_hi = '0; prev_lo = '0;
    do_op("mul_3x3", ALU_MUL, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0, N, 1'b0);

    // Back-to-back: second start issued on the first idle cycle after FIN.
    do_op("b2b_mul_2x3", ALU_MUL, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, N, 1'b0);
    do_op("b2b_div_9_2", ALU_DIV, 32'd9, 32'd2, 32'd1, 32'd4, 1'b0, N, 1'b0);

    for (int i = 0; i < 30; i++) begin
      op = ($urandom_range(0, 1) == 0) ? ALU_MUL : ALU_DIV;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      model(op, a, b, ehi, elo, edz, elat);
      do_op($sformatf("rand%0d", i), op, a, b, ehi, elo, edz, elat, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
